wb_dma: RTL

- Single-channel Wishbone memory-to-memory copy engine.
- Has two bus ports:
  - A slave register port on a conbus slave slot, programmed by the LM32.
  - A master port on the free conbus master slot m2.
- Copies LEN 32-bit words from SRC to DST. Each word is one classic read cycle followed by one classic write cycle.
- Raises a level interrupt on completion.

---
 rtl/wb_dma_pkg.sv | 25 ++
 rtl/wb_dma_regs.sv | 106 ++++++++++
 rtl/wb_dma.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wb_dma_pkg.sv
// Shared definitions for the wb_dma copy engine: register offsets,
// CTRL bit positions and the master state encoding.
package wb_dma_pkg;

    // Register offsets, selected by wbs_adr_i[3:2]
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_IE    = 3;
    localparam int CTRL_ABORT = 4;

    // Master bus state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

endpackage

// File: rtl/wb_dma_regs.sv
// Slave register port of wb_dma: address decode, registered single-cycle
// ack, the SRC/DST/LEN working counters and the CTRL status bits.
module wb_dma_regs
    import wb_dma_pkg::*;
#(
    parameter int len_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           offset,
    input  logic [31:0]          wbs_dat_i,
    output logic [31:0]          wbs_dat_o,
    input  logic                 wbs_we_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    output logic                 wbs_ack_o,
    input  logic                 busy,
    input  logic                 step,
    input  logic                 set_done,
    input  logic                 clr_done,
    output logic [31:0]          src,
    output logic [31:0]          dst,
    output logic [len_width-1:0] len,
    output logic                 start_req,
    output logic                 abort_req,
    output logic                 done,
    output logic                 ie
);

    logic        access;
    logic        wr_en;
    logic        ctrl_wr;
    logic [31:0] rd_data;

    // A new access is one not already being acknowledged this cycle
    assign access  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr_en   = access & wbs_we_i;
    assign ctrl_wr = wr_en && (offset == REG_CTRL);

    // Read-data mux; START and ABORT always read back as 0
    always_comb begin
        rd_data = '0;
        case (offset)
            REG_SRC: rd_data = src;
            REG_DST: rd_data = dst;
            REG_LEN: rd_data = 32'(len);
            default: begin
                rd_data[CTRL_BUSY] = busy;
                rd_data[CTRL_DONE] = done;
                rd_data[CTRL_IE]   = ie;
            end
        endcase
    end

    // Ack pulse and read data, registered together
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access;
            if (access) wbs_dat_o <= rd_data;
        end
    end

    // Working counters: bus writes only while idle, stepping only while busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src <= '0;
            dst <= '0;
            len <= '0;
        end else if (step) begin
            src <= src + 32'd4;
            dst <= dst + 32'd4;
            len <= len - len_width'(1);
        end else if (wr_en && !busy) begin
            case (offset)
                REG_SRC: src <= {wbs_dat_i[31:2], 2'b00};
                REG_DST: dst <= {wbs_dat_i[31:2], 2'b00};
                REG_LEN: len <= wbs_dat_i[len_width-1:0];
                default: ;
            endcase
        end
    end

    // CTRL bits: IE, sticky DONE, and single-cycle START/ABORT requests
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie        <= 1'b0;
            done      <= 1'b0;
            start_req <= 1'b0;
            abort_req <= 1'b0;
        end else begin
            start_req <= ctrl_wr & wbs_dat_i[CTRL_START] & ~busy;
            abort_req <= ctrl_wr & wbs_dat_i[CTRL_ABORT];
            if (ctrl_wr) ie <= wbs_dat_i[CTRL_IE];
            if (set_done)
                done <= 1'b1;
            else if (clr_done || (ctrl_wr && wbs_dat_i[CTRL_DONE]))
                done <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_dma.sv
// wb_dma top: single-channel Wishbone memory-to-memory copy engine.
// One classic read then one classic write per word; cyc stays asserted
// for the whole transfer so the bus grant is held.
module wb_dma
    import wb_dma_pkg::*;
#(
    parameter int len_width = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    output logic        intr
);

    state_t                state, state_n;
    logic                  cyc_n, stb_n, we_n;
    logic [31:0]           adr_n, dat_n;
    logic                  step, set_done, clr_done;
    logic                  abort_pend;
    logic                  busy;
    logic [31:0]           src, dst;
    logic [len_width-1:0]  len;
    logic                  start_req, abort_req, done, ie;
    logic                  unused;

    // Only full-word accesses at adr[3:2] are decoded
    assign unused    = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};
    assign wbm_sel_o = 4'hF;
    assign busy      = (state != IDLE);
    assign intr      = done & ie;

    wb_dma_regs #(.len_width(len_width)) u_regs (
        .clk       (clk),
        .rst       (rst),
        .offset    (wbs_adr_i[3:2]),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_we_i  (wbs_we_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_ack_o (wbs_ack_o),
        .busy      (busy),
        .step      (step),
        .set_done  (set_done),
        .clr_done  (clr_done),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .start_req (start_req),
        .abort_req (abort_req),
        .done      (done),
        .ie        (ie)
    );

    // Next state and next registered bus outputs
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n  = state;
        cyc_n    = wbm_cyc_o;
        stb_n    = wbm_stb_o;
        we_n     = wbm_we_o;
        adr_n    = wbm_adr_o;
        dat_n    = wbm_dat_o;
        step     = 1'b0;
        set_done = 1'b0;
        clr_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    if (len != '0) begin
                        state_n  = RD;
                        cyc_n    = 1'b1;
                        stb_n    = 1'b1;
                        we_n     = 1'b0;
                        adr_n    = src;
                        clr_done = 1'b1;
                    end else begin
                        set_done = 1'b1;
                    end
                end
            end
            RD: begin
                if (wbm_ack_i) begin
                    state_n = WR;
                    we_n    = 1'b1;
                    adr_n   = dst;
                    dat_n   = wbm_dat_i;   // wbm_dat_o is the one-word buffer
                end
            end
            WR: begin
                if (wbm_ack_i) begin
                    step = 1'b1;
                    if (len == len_width'(1) || abort_pend || abort_req) begin
                        state_n  = IDLE;
                        cyc_n    = 1'b0;
                        stb_n    = 1'b0;
                        we_n     = 1'b0;
                        set_done = 1'b1;
                    end else begin
                        state_n = RD;
                        we_n    = 1'b0;
                        adr_n   = src + 32'd4;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cyc_n   = 1'b0;
                stb_n   = 1'b0;
                we_n    = 1'b0;
            end
        endcase
    end

    // State and bus output registers; reset drops cyc/stb immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            state     <= state_n;
            wbm_cyc_o <= cyc_n;
            wbm_stb_o <= stb_n;
            wbm_we_o  <= we_n;
            wbm_adr_o <= adr_n;
            wbm_dat_o <= dat_n;
        end
    end

    // Abort is remembered only while a transfer is running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            abort_pend <= 1'b0;
        else
            abort_pend <= (state_n != IDLE) && (abort_pend || (abort_req && busy));
    end

endmodule
